// File: rtl/vga_sync_gen_pkg.sv
// Display-pipeline shared definitions: VGA 640x480@60 timing, playfield tiling, colour type.
package display_pkg;
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned SCREEN_COLS = 10;
    localparam int unsigned SCREEN_ROWS = 10;
    localparam int unsigned TILE_W      = 64;
    localparam int unsigned TILE_H      = 48;

    localparam int unsigned COORD_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;
endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle driven by vga_sync_gen and consumed by the colour generators.
interface vga_sync_gen_if;
    logic       pix_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic [3:0] tile_col;
    logic [3:0] tile_row;

    modport master (output pix_tick, x, y, on, hsync, vsync, frame_start, tile_col, tile_row);
    modport slave  (input  pix_tick, x, y, on, hsync, vsync, frame_start, tile_col, tile_row);
endinterface

// File: rtl/vga_sync_gen_axis.sv
// One timing axis: wrapping counter plus a registered active-low sync window.
// Exposes the next count and visibility so the top can register decodes aligned with it.
module sync_axis_counter #(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned VISIBLE    = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_LEN   = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [9:0] cnt_o,
    output logic [9:0] cnt_d_o,
    output logic       wrap_o,
    output logic       vis_d_o,
    output logic       sync_n_o
);
    localparam logic [9:0] LAST     = 10'(TOTAL - 1);
    localparam logic [9:0] VIS_END  = 10'(VISIBLE);
    localparam logic [9:0] SYNC_BEG = 10'(SYNC_START);
    localparam logic [9:0] SYNC_END = 10'(SYNC_START + SYNC_LEN);

    logic [9:0] cnt_q, cnt_d;
    logic       sync_n_q, sync_n_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = (cnt_q == LAST) ? 10'd0 : cnt_q + 10'd1;
        sync_n_d = !((cnt_d >= SYNC_BEG) && (cnt_d < SYNC_END));
    end

    // Reset to the last count so the first enable lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= LAST;
            sync_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign cnt_d_o  = cnt_d;
    assign wrap_o   = (cnt_q == LAST);
    assign vis_d_o  = (cnt_d < VIS_END);
    assign sync_n_o = sync_n_q;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, H/V axis counters and registered
// on/sync/tile/frame_start decodes that change on the same edge as x/y.
module vga_sync_gen
    import display_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned HV      = H_VISIBLE,
    parameter int unsigned HFP     = H_FP,
    parameter int unsigned HS      = H_SYNC,
    parameter int unsigned HBP     = H_BP,
    parameter int unsigned VV      = V_VISIBLE,
    parameter int unsigned VFP     = V_FP,
    parameter int unsigned VS      = V_SYNC,
    parameter int unsigned VBP     = V_BP,
    parameter int unsigned TW      = TILE_W,
    parameter int unsigned TH      = TILE_H
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master sync_o
);
    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam int unsigned TILE_SHIFT = $clog2(TW);
    localparam logic [9:0] TH_LAST    = 10'(TH - 1);
    localparam logic [9:0] V_VIS_END  = 10'(VV);

    logic [3:0] div_q, div_d;
    logic       tick_d;

    assign tick_d = (div_q == DIV_LAST);
    assign div_d  = tick_d ? 4'd0 : div_q + 4'd1;

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       h_wrap, v_wrap, h_vis_d, v_vis_d, hsync_n, vsync_n;

    sync_axis_counter #(
        .TOTAL(HV + HFP + HS + HBP), .VISIBLE(HV), .SYNC_START(HV + HFP), .SYNC_LEN(HS)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .en_i(tick_d),
        .cnt_o(x_q), .cnt_d_o(x_d), .wrap_o(h_wrap), .vis_d_o(h_vis_d), .sync_n_o(hsync_n)
    );

    sync_axis_counter #(
        .TOTAL(VV + VFP + VS + VBP), .VISIBLE(VV), .SYNC_START(VV + VFP), .SYNC_LEN(VS)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .en_i(tick_d & h_wrap),
        .cnt_o(y_q), .cnt_d_o(y_d), .wrap_o(v_wrap), .vis_d_o(v_vis_d), .sync_n_o(vsync_n)
    );

    // Row tile index tracked incrementally so no divide by TILE_H is needed.
    logic [9:0] row_pix_q, row_pix_d;
    logic [3:0] row_idx_q, row_idx_d;

    always_comb begin
        row_pix_d = row_pix_q;
        row_idx_d = row_idx_q;
        if (tick_d && h_wrap) begin
            if (v_wrap) begin
                row_pix_d = 10'd0;
                row_idx_d = 4'd0;
            end else if (row_pix_q == TH_LAST) begin
                row_pix_d = 10'd0;
                if (row_idx_q != 4'hF) row_idx_d = row_idx_q + 4'd1;
            end else begin
                row_pix_d = row_pix_q + 10'd1;
            end
        end
    end

    logic       on_d, fs_d;
    logic [3:0] tcol_d, trow_d;

    assign on_d   = h_vis_d & v_vis_d;
    assign fs_d   = tick_d & h_wrap & v_wrap;
    assign tcol_d = on_d ? 4'(x_d >> TILE_SHIFT) : 4'hF;
    assign trow_d = (y_d < V_VIS_END) ? row_idx_d : 4'hF;

    logic       tick_q, on_q, fs_q;
    logic [3:0] tcol_q, trow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= 4'd0;
            tick_q    <= 1'b0;
            on_q      <= 1'b0;
            fs_q      <= 1'b0;
            tcol_q    <= 4'hF;
            trow_q    <= 4'hF;
            row_pix_q <= 10'd0;
            row_idx_q <= 4'd0;
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            on_q      <= on_d;
            fs_q      <= fs_d;
            tcol_q    <= tcol_d;
            trow_q    <= trow_d;
            row_pix_q <= row_pix_d;
            row_idx_q <= row_idx_d;
        end
    end

    assign sync_o.pix_tick    = tick_q;
    assign sync_o.x           = x_q;
    assign sync_o.y           = y_q;
    assign sync_o.on          = on_q;
    assign sync_o.hsync       = hsync_n;
    assign sync_o.vsync       = vsync_n;
    assign sync_o.frame_start = fs_q;
    assign sync_o.tile_col    = tcol_q;
    assign sync_o.tile_row    = trow_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Checks a full-size VGA generator (CLK_DIV=4) and a shrunken-geometry CLK_DIV=1 build
// against an arithmetic model of tick count -> (x, y, sync, tile) with random mid-frame resets.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n [2];
    int   cyc   [2];
    int   checks = 0;
    int   errors = 0;

    vga_sync_gen_if ia ();
    vga_sync_gen_if ib ();

    vga_sync_gen #(.CLK_DIV(4)) u_full (.clk(clk), .rst_n(rst_n[0]), .sync_o(ia));

    vga_sync_gen #(
        .CLK_DIV(1), .HV(40), .HFP(4), .HS(6), .HBP(6),
        .VV(30), .VFP(2), .VS(2), .VBP(3), .TW(4), .TH(3)
    ) u_small (.clk(clk), .rst_n(rst_n[1]), .sync_o(ib));

    logic [32:0] obs [2];
    assign obs[0] = {ia.pix_tick, ia.x, ia.y, ia.on, ia.hsync, ia.vsync, ia.frame_start, ia.tile_col, ia.tile_row};
    assign obs[1] = {ib.pix_tick, ib.x, ib.y, ib.on, ib.hsync, ib.vsync, ib.frame_start, ib.tile_col, ib.tile_row};

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h {tick,x,y,on,hs,vs,fs,tc,tr}", tag, got, exp);
        end
    endtask

    // Expected outputs c clocks after reset release, straight from the timing rules.
    function automatic logic [32:0] model(input int d, input int c);
        int div, hv, hfp, hs, ht, vv, vfp, vs, vt, tw, th, k, p, x, y;
        logic tk, on, hsn, vsn, fs;
        logic [3:0] tc, tr;
        if (d == 0) begin
            div = 4; hv = 640; hfp = 16; hs = 96; ht = 800;
            vv = 480; vfp = 10; vs = 2; vt = 525; tw = 64; th = 48;
        end else begin
            div = 1; hv = 40; hfp = 4; hs = 6; ht = 56;
            vv = 30; vfp = 2; vs = 2; vt = 37; tw = 4; th = 3;
        end
        k  = c / div;
        tk = (c > 0) && (c % div == 0);
        if (k == 0) return {1'b0, 10'(ht - 1), 10'(vt - 1), 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF};
        p   = (k - 1) % (ht * vt);
        x   = p % ht;
        y   = p / ht;
        on  = (x < hv) && (y < vv);
        hsn = !((x >= hv + hfp) && (x < hv + hfp + hs));
        vsn = !((y >= vv + vfp) && (y < vv + vfp + vs));
        fs  = tk && (p == 0);
        tc  = on ? 4'(x / tw) : 4'hF;
        tr  = (y < vv) ? 4'(y / th) : 4'hF;
        return {tk, 10'(x), 10'(y), on, hsn, vsn, fs, tc, tr};
    endfunction

    task automatic run(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc[d]++;
            @(negedge clk);
            chk($sformatf("d%0d_c%0d", d, cyc[d]), obs[d], model(d, cyc[d]));
        end
    endtask

    // Assert reset between edges and expect reset values before any clock edge.
    task automatic do_reset(input int d);
        @(negedge clk);
        #1 rst_n[d] = 1'b0;
        #1 chk($sformatf("d%0d_async_rst", d), obs[d], model(d, 0));
        repeat (2) @(negedge clk);
        chk($sformatf("d%0d_rst_hold", d), obs[d], model(d, 0));
        rst_n[d] = 1'b1;
        cyc[d]   = 0;
    endtask

    initial begin
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        cyc[0]   = 0;
        cyc[1]   = 0;
        fork
            begin
                do_reset(0);
                run(0, 4000);
                for (int r = 0; r < 3; r++) begin
                    do_reset(0);
                    run(0, int'($urandom_range(300, 5000)));
                end
            end
            begin
                do_reset(1);
                run(1, 2 * 56 * 37 + 60);
                for (int r = 0; r < 4; r++) begin
                    do_reset(1);
                    run(1, int'($urandom_range(100, 3000)));
                end
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
